// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the two-requester ALU scheduler.
// Flag bit positions match the ALU's {ERR,OFLOW,COUT,G,L,E} output.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int FLG_ERR   = 5;
    localparam int FLG_OFLOW = 4;
    localparam int FLG_COUT  = 3;
    localparam int FLG_G     = 2;
    localparam int FLG_L     = 1;
    localparam int FLG_E     = 0;
    localparam int NUM_FLAGS = FLG_ERR + 1;

    localparam int unsigned CMD_MUL_A = 9;
    localparam int unsigned CMD_MUL_B = 10;

    // Multiply-class commands take the long result path through the ALU.
    function automatic logic is_long_op(input logic mode, input int unsigned cmd);
        return mode && (cmd == CMD_MUL_A || cmd == CMD_MUL_B);
    endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Requester, ALU and response signal bundle seen by the scheduler.
// slave = scheduler side, master = requesters plus ALU side.
interface alu_req_scheduler_if
    import alu_sched_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*W-1:0]       req_opa;
    logic [2*W-1:0]       req_opb;
    logic [1:0]           req_cin;
    logic [1:0]           req_mode;
    logic [2*N-1:0]       req_cmd;

    logic                 alu_ce;
    logic [W-1:0]         alu_opa;
    logic [W-1:0]         alu_opb;
    logic                 alu_cin;
    logic                 alu_mode;
    logic [1:0]           alu_inp_valid;
    logic [N-1:0]         alu_cmd;
    logic [W:0]           alu_res;
    logic [NUM_FLAGS-1:0] alu_flags;

    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [W:0]           resp_res;
    logic [NUM_FLAGS-1:0] resp_flags;

    modport slave (
        input  req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd,
        output req_ready,
        output alu_ce, alu_opa, alu_opb, alu_cin, alu_mode, alu_inp_valid, alu_cmd,
        input  alu_res, alu_flags,
        output resp_valid, resp_res, resp_flags,
        input  resp_ready
    );

    modport master (
        output req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd,
        input  req_ready,
        input  alu_ce, alu_opa, alu_opb, alu_cin, alu_mode, alu_inp_valid, alu_cmd,
        output alu_res, alu_flags,
        input  resp_valid, resp_res, resp_flags,
        output resp_ready
    );

endinterface

// File: rtl/alu_req_scheduler_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
// Purely combinational; grant is one-hot or zero and only covers valid requests.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between two requesters: accept, issue both operands at once,
// wait the command latency, capture the result and hand it back to its owner.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int W        = 8,
    parameter int N        = 4,
    parameter int MUL_LAT  = 3,
    parameter int BASE_LAT = 1
) (
    input  logic               clk,
    input  logic               RST,
    alu_req_scheduler_if.slave bus,
    output logic               busy
);

    localparam int MAX_LAT = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef struct packed {
        state_e               state;
        logic [CNT_W-1:0]     cnt;
        logic                 owner;
        logic                 last;
        logic                 long_op;
        logic [W-1:0]         opa;
        logic [W-1:0]         opb;
        logic                 cin;
        logic                 mode;
        logic [N-1:0]         cmd;
        logic [1:0]           inp_valid;
        logic                 ce;
        logic [1:0]           resp_valid;
        logic [W:0]           res;
        logic [NUM_FLAGS-1:0] flags;
        logic                 busy;
    } regs_t;

    regs_t r_q, r_d;

    logic [1:0]   grant;
    logic         win;
    logic [W-1:0] opa_sel;
    logic [W-1:0] opb_sel;
    logic [N-1:0] cmd_sel;

    rr_arb2 u_arb (
        .req_i   (bus.req_valid),
        .last_i  (r_q.last),
        .grant_o (grant)
    );

    assign win     = grant[1];
    assign opa_sel = win ? bus.req_opa[2*W-1:W] : bus.req_opa[W-1:0];
    assign opb_sel = win ? bus.req_opb[2*W-1:W] : bus.req_opb[W-1:0];
    assign cmd_sel = win ? bus.req_cmd[2*N-1:N] : bus.req_cmd[N-1:0];

    // A reset cycle never completes a transfer, so do not advertise one.
    assign bus.req_ready = (r_q.state == ST_IDLE && !RST) ? grant : 2'b00;

    always_comb begin
        // NOTE: full default first so no path through the case leaves a field unassigned (no latches).
        r_d = r_q;
        case (r_q.state)
            ST_IDLE: begin
                if (|grant) begin
                    r_d.owner     = win;
                    r_d.opa       = opa_sel;
                    r_d.opb       = opb_sel;
                    r_d.cin       = bus.req_cin[win];
                    r_d.mode      = bus.req_mode[win];
                    r_d.cmd       = cmd_sel;
                    r_d.long_op   = is_long_op(bus.req_mode[win], 32'(cmd_sel));
                    r_d.inp_valid = 2'b11;
                    r_d.ce        = 1'b1;
                    r_d.busy      = 1'b1;
                    r_d.state     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                r_d.cnt       = r_q.long_op ? CNT_W'(MUL_LAT) : CNT_W'(BASE_LAT);
                r_d.inp_valid = 2'b00;
                r_d.state     = ST_WAIT;
            end
            ST_WAIT: begin
                r_d.cnt = r_q.cnt - 1'b1;
                if (r_q.cnt == CNT_W'(1)) begin
                    r_d.res        = bus.alu_res;
                    r_d.flags      = bus.alu_flags;
                    r_d.ce         = 1'b0;
                    r_d.resp_valid = 2'b01 << r_q.owner;
                    r_d.state      = ST_RESP;
                end
            end
            ST_RESP: begin
                // Only the owner's ready completes the response.
                if (bus.resp_ready[r_q.owner]) begin
                    r_d.last       = r_q.owner;
                    r_d.resp_valid = 2'b00;
                    r_d.busy       = 1'b0;
                    r_d.state      = ST_IDLE;
                end
            end
            default: r_d.state = ST_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_q       <= '0;
            r_q.state <= ST_IDLE;
            r_q.last  <= 1'b1;
        end else begin
            r_q <= r_d;
        end
    end

    assign bus.alu_ce        = r_q.ce;
    assign bus.alu_opa       = r_q.opa;
    assign bus.alu_opb       = r_q.opb;
    assign bus.alu_cin       = r_q.cin;
    assign bus.alu_mode      = r_q.mode;
    assign bus.alu_inp_valid = r_q.inp_valid;
    assign bus.alu_cmd       = r_q.cmd;
    assign bus.resp_valid    = r_q.resp_valid;
    assign bus.resp_res      = r_q.res;
    assign bus.resp_flags    = r_q.flags;
    assign busy              = r_q.busy;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared each
// cycle against a transaction-timeline model of the scheduler.
module tb_alu_req_scheduler;
    import alu_sched_pkg::*;

    localparam int W        = 8;
    localparam int N        = 4;
    localparam int MUL_LAT  = 3;
    localparam int BASE_LAT = 1;

    logic clk = 1'b0;
    logic RST;
    logic busy;

    alu_req_scheduler_if #(.W(W), .N(N)) bus ();

    alu_req_scheduler #(
        .W        (W),
        .N        (N),
        .MUL_LAT  (MUL_LAT),
        .BASE_LAT (BASE_LAT)
    ) dut (
        .clk  (clk),
        .RST  (RST),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: at most one operation in flight, described by its accept cycle.
    bit           inflight;
    bit           fresh;
    int           t_acc;
    int           m_owner;
    int           m_lat;
    int           m_last;
    logic [W-1:0] m_opa, m_opb;
    logic         m_cin, m_mode;
    logic [N-1:0] m_cmd;
    logic [W:0]   m_res;
    logic [5:0]   m_flags;

    logic [1:0]   acc_mask;
    int           grant_log[$];
    int           acc_log[$];
    int           lat_log[$];

    int           n_issue, n_wait, resp_seen_cyc;
    logic [1:0]   resp_seen_val;
    logic [W:0]   resp_seen_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_marks();
        n_issue       = 0;
        n_wait        = 0;
        resp_seen_cyc = -1;
        resp_seen_val = 2'b00;
        resp_seen_res = '0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic m, input logic [N-1:0] cmd);
        bus.req_opa[i*W +: W] = a;
        bus.req_opb[i*W +: W] = b;
        bus.req_cin[i]        = c;
        bus.req_mode[i]       = m;
        bus.req_cmd[i*N +: N] = cmd;
    endtask

    task automatic rand_req(input int i);
        logic [N-1:0] cmd;
        cmd = ($urandom_range(2) == 0) ? N'(9 + $urandom_range(1)) : N'($urandom_range(15));
        set_req(i, W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), cmd);
    endtask

    // One clock cycle: drive the ALU stand-in, compare outputs, advance the model.
    task automatic tick();
        int         w;
        int         k;
        logic [1:0] e_ready, e_iv, e_rv;
        logic       e_ce, e_busy;
        logic [W:0] sum;
        logic [5:0] fl;

        k = cyc - t_acc;
        if (inflight && k == 1 + m_lat) begin
            sum            = {1'b0, m_opa} + {1'b0, m_opb} + {{W{1'b0}}, m_cin};
            fl             = '0;
            fl[FLG_E]      = (m_opa == m_opb);
            fl[FLG_G]      = (m_opa > m_opb);
            fl[FLG_L]      = (m_opa < m_opb);
            fl[FLG_COUT]   = sum[W];
            fl[FLG_OFLOW]  = 1'($urandom_range(1));
            fl[FLG_ERR]    = 1'($urandom_range(1));
            bus.alu_res    = sum;
            bus.alu_flags  = fl;
        end else begin
            bus.alu_res    = (W+1)'($urandom);
            bus.alu_flags  = 6'($urandom);
        end
        #1;

        w = -1;
        if (!inflight) begin
            if (bus.req_valid == 2'b11)      w = 1 - m_last;
            else if (bus.req_valid == 2'b01) w = 0;
            else if (bus.req_valid == 2'b10) w = 1;
        end
        e_ready = (w >= 0) ? 2'(1 << w) : 2'b00;
        e_iv = 2'b00; e_ce = 1'b0; e_rv = 2'b00; e_busy = 1'b0;
        if (inflight) begin
            e_busy = 1'b1;
            if (k == 1) begin
                e_iv = 2'b11;
                e_ce = 1'b1;
            end else if (k <= 1 + m_lat) begin
                e_ce = 1'b1;
            end else begin
                e_rv = 2'(1 << m_owner);
            end
        end

        check("req_ready",     32'(bus.req_ready),     32'(e_ready));
        check("alu_inp_valid", 32'(bus.alu_inp_valid), 32'(e_iv));
        check("alu_ce",        32'(bus.alu_ce),        32'(e_ce));
        check("resp_valid",    32'(bus.resp_valid),    32'(e_rv));
        check("busy",          32'(busy),              32'(e_busy));
        if (inflight && k <= 1 + m_lat) begin
            check("alu_opa",  32'(bus.alu_opa),  32'(m_opa));
            check("alu_opb",  32'(bus.alu_opb),  32'(m_opb));
            check("alu_cin",  32'(bus.alu_cin),  32'(m_cin));
            check("alu_mode", 32'(bus.alu_mode), 32'(m_mode));
            check("alu_cmd",  32'(bus.alu_cmd),  32'(m_cmd));
        end
        if (inflight && k >= 2 + m_lat) begin
            check("resp_res",   32'(bus.resp_res),   32'(m_res));
            check("resp_flags", 32'(bus.resp_flags), 32'(m_flags));
        end
        if (fresh) begin
            check("rst_alu_fields", 32'({bus.alu_opa, bus.alu_opb, bus.alu_cin, bus.alu_mode, bus.alu_cmd}), 32'(0));
            check("rst_resp_data",  32'({bus.resp_res, bus.resp_flags}), 32'(0));
        end
        check("inp_valid_legal", 32'(bus.alu_inp_valid == 2'b01 || bus.alu_inp_valid == 2'b10), 32'(0));
        check("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'(1));

        if (bus.alu_inp_valid == 2'b11) n_issue++;
        if (bus.alu_ce && bus.alu_inp_valid == 2'b00) n_wait++;
        if (bus.resp_valid != 2'b00 && resp_seen_cyc < 0) begin
            resp_seen_cyc = cyc;
            resp_seen_val = bus.resp_valid;
            resp_seen_res = bus.resp_res;
        end

        acc_mask = 2'b00;
        if (RST) begin
            inflight = 1'b0;
            m_last   = 1;
            fresh    = 1'b1;
        end else if (!inflight) begin
            if (w >= 0) begin
                inflight = 1'b1;
                t_acc    = cyc;
                m_owner  = w;
                m_opa    = bus.req_opa[w*W +: W];
                m_opb    = bus.req_opb[w*W +: W];
                m_cin    = bus.req_cin[w];
                m_mode   = bus.req_mode[w];
                m_cmd    = bus.req_cmd[w*N +: N];
                m_lat    = (m_mode && (m_cmd == 9 || m_cmd == 10)) ? MUL_LAT : BASE_LAT;
                fresh    = 1'b0;
                acc_mask[w] = 1'b1;
                grant_log.push_back(w);
                acc_log.push_back(cyc);
                lat_log.push_back(m_lat);
            end
        end else begin
            if (k == 1 + m_lat) begin
                m_res   = bus.alu_res;
                m_flags = bus.alu_flags;
            end
            if (k >= 2 + m_lat && bus.resp_ready[m_owner]) begin
                inflight = 1'b0;
                m_last   = m_owner;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b11;
        for (int i = 0; i < 12 && inflight; i++) tick();
        check("drain_idle", 32'(inflight), 32'(0));
        tick();
    endtask

    initial begin
        int t0, g0;
        RST            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_opa    = '0;
        bus.req_opb    = '0;
        bus.req_cin    = '0;
        bus.req_mode   = '0;
        bus.req_cmd    = '0;
        bus.resp_ready = 2'b00;
        bus.alu_res    = '0;
        bus.alu_flags  = '0;
        inflight = 1'b0;
        fresh    = 1'b1;
        m_last   = 1;
        t_acc    = 0;
        clear_marks();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        RST = 1'b0;
        tick();

        // Single short op from requester 0.
        set_req(0, 8'h0F, 8'h01, 1'b0, 1'b1, 4'd0);
        bus.req_valid  = 2'b01;
        bus.resp_ready = 2'b11;
        clear_marks();
        t0 = cyc;
        tick();
        bus.req_valid = 2'b00;
        repeat (6) tick();
        check("single_resp_lat",  32'(resp_seen_cyc - t0), 32'(3));
        check("single_resp_own",  32'(resp_seen_val),      32'(2'b01));
        check("single_resp_res",  32'(resp_seen_res),      32'(9'h010));
        check("single_issue_cyc", 32'(n_issue),            32'(1));

        // Long (multiply-class) op from requester 1.
        set_req(1, 8'd3, 8'd4, 1'b0, 1'b1, 4'd9);
        bus.req_valid = 2'b10;
        clear_marks();
        t0 = cyc;
        tick();
        bus.req_valid = 2'b00;
        repeat (8) tick();
        check("long_resp_lat", 32'(resp_seen_cyc - t0), 32'(5));
        check("long_resp_own", 32'(resp_seen_val),      32'(2'b10));
        check("long_wait_cyc", 32'(n_wait),             32'(3));

        // Contention: both requesters always valid, responses accepted at once.
        rand_req(0);
        rand_req(1);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        g0 = grant_log.size();
        repeat (40) begin
            tick();
            for (int i = 0; i < 2; i++) if (acc_mask[i]) rand_req(i);
        end
        check("rr_grant_count", 32'(grant_log.size() - g0 >= 4), 32'(1));
        for (int j = g0 + 1; j < grant_log.size(); j++) begin
            check("rr_alternate", 32'(grant_log[j]), 32'(1 - grant_log[j-1]));
            check("rr_spacing",   32'(acc_log[j] - acc_log[j-1]), 32'(lat_log[j-1] + 3));
        end
        drain();

        // Backpressure: hold RESP for 10 cycles while requester 1 waits.
        rand_req(0);
        bus.req_valid  = 2'b01;
        bus.resp_ready = 2'b00;
        tick();
        rand_req(1);
        bus.req_valid = 2'b10;
        for (int i = 0; i < 10 && !(inflight && cyc - t_acc >= 2 + m_lat); i++) tick();
        check("bp_reached_resp", 32'(inflight && cyc - t_acc >= 2 + m_lat), 32'(1));
        for (int i = 0; i < 10; i++) begin
            bus.resp_ready = (i % 2 == 0) ? 2'b00 : 2'b10;
            tick();
        end
        bus.resp_ready = 2'b01;
        tick();
        check("bp_done_next_cycle", 32'(busy), 32'(0));
        bus.resp_ready = 2'b11;
        tick();
        check("bp_waiter_granted", 32'(acc_mask), 32'(2'b10));
        drain();

        // Reset in the middle of a long op's WAIT phase.
        set_req(0, W'($urandom), W'($urandom), 1'b0, 1'b1, 4'd9);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_busy_clear", 32'(busy), 32'(0));
        clear_marks();
        repeat (8) tick();
        check("rst_no_resp", 32'(resp_seen_cyc), 32'(-1));
        rand_req(0);
        rand_req(1);
        bus.req_valid = 2'b11;
        g0 = grant_log.size();
        tick();
        check("rst_tie_req0", 32'(acc_mask), 32'(2'b01));
        bus.req_valid = 2'b10;
        for (int i = 0; i < 12 && grant_log.size() - g0 < 2; i++) tick();
        check("rst_next_accepted", 32'(grant_log.size() - g0), 32'(2));
        drain();

        // Random traffic with occasional backpressure and resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] || acc_mask[i]) begin
                    if ($urandom_range(99) < 50) begin
                        bus.req_valid[i] = 1'b1;
                        rand_req(i);
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            bus.resp_ready[0] = ($urandom_range(99) < 70);
            bus.resp_ready[1] = ($urandom_range(99) < 70);
            RST = ($urandom_range(199) == 0);
            if (RST) bus.req_valid = 2'b00;
            tick();
        end
        RST = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
